// File: rtl/switch_response.sv
// Switch-side answer path: synchronizes and debounces the player switches, then
// scores them against the LED pattern of the current round.
// Optional: SWITCH_RESPONSE_CHANGE_REQUIRED_EN makes a hit require at least one
// debounced switch toggle since arming.
//
//   state   | meaning
//   --------+---------------------------------------------
//   S_IDLE  | no round presented since reset
//   S_ARMED | round in progress, waiting for switches == target
//   S_DONE  | round answered, waiting for the next round_start
module switch_response #(
    parameter int WIDTH        = 8,
    parameter int STABLE_TICKS = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             scan_tick,
    input  logic             round_start,
    input  logic [WIDTH-1:0] led_control,
    input  logic [WIDTH-1:0] switch,
    output logic [WIDTH-1:0] sw_stable,
    output logic             hit,
    output logic             miss,
    output logic             armed
);

    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [CW-1:0] TC = CW'(STABLE_TICKS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sw_meta, sw_sync;
    logic [WIDTH-1:0] stable_d;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] target_q, target_d;
    logic             hit_d, miss_d;
    logic             match;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

    // A counter only advances while the synchronized level disagrees with the
    // accepted level; any agreeing tick restarts the run.
    always_comb begin
        stable_d = sw_stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (scan_tick) begin
                if (sw_sync[i] != sw_stable[i]) begin
                    if (cnt_q[i] + CW'(1) == TC) begin
                        stable_d[i] = ~sw_stable[i];
                        cnt_d[i]    = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sw_stable <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sw_stable <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SWITCH_RESPONSE_CHANGE_REQUIRED_EN
    logic changed_q, changed_d;

    always_comb begin
        changed_d = changed_q;
        if (round_start) begin
            changed_d = 1'b0;
        end else if (state_q == S_ARMED && stable_d != sw_stable) begin
            changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign match = (state_q == S_ARMED) && (sw_stable == target_q) && changed_q;
`else
    assign match = (state_q == S_ARMED) && (sw_stable == target_q);
`endif

    // round_start always re-arms; a simultaneous match still scores as a hit.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        if (match) begin
            hit_d = 1'b1;
        end else if (state_q == S_ARMED && round_start) begin
            miss_d = 1'b1;
        end
        if (round_start) begin
            state_d  = S_ARMED;
            target_d = led_control;
        end else if (match) begin
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_IDLE;
            target_q <= '0;
            hit      <= 1'b0;
            miss     <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            hit      <= hit_d;
            miss     <= miss_d;
        end
    end

    assign armed = (state_q == S_ARMED);

endmodule

// File: tb/tb_switch_response.sv
// Bench for switch_response: directed vector table, hand-built round corner
// cases, then random traffic against a behavioural model of the round rules.
module tb_switch_response;

    localparam int W  = 8;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         clr;
    logic         scan_tick;
    logic         round_start;
    logic [W-1:0] led_control;
    logic [W-1:0] switch;
    logic [W-1:0] sw_stable;
    logic         hit, miss, armed;

    int checks = 0;
    int errors = 0;

    switch_response #(.WIDTH(W), .STABLE_TICKS(ST)) dut (
        .clk         (clk),
        .clr         (clr),
        .scan_tick   (scan_tick),
        .round_start (round_start),
        .led_control (led_control),
        .switch      (switch),
        .sw_stable   (sw_stable),
        .hit         (hit),
        .miss        (miss),
        .armed       (armed)
    );

    always #5 clk = ~clk;

    // Reference model: raw switch history, per-bit run lengths, round bookkeeping.
    logic [W-1:0] hist [$];
    int           run [W];
    logic [W-1:0] m_stable, m_target;
    logic         m_waiting, m_changed, m_hit, m_miss;

    task automatic model_reset();
        hist = {8'h00, 8'h00};
        for (int i = 0; i < W; i++) run[i] = 0;
        m_stable = '0; m_target = '0;
        m_waiting = 0; m_changed = 0; m_hit = 0; m_miss = 0;
    endtask

    task automatic model_step();
        logic [W-1:0] seen, nxt;
        logic         ok;
        if (!clr) begin
            model_reset();
            return;
        end
        seen = hist[0];
        hist.push_back(switch);
        void'(hist.pop_front());
        nxt = m_stable;
        if (scan_tick) begin
            for (int i = 0; i < W; i++) begin
                if (seen[i] != m_stable[i]) begin
                    run[i]++;
                    if (run[i] == ST) begin
                        nxt[i] = ~m_stable[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
        end
        ok = m_waiting && (m_stable == m_target);
`ifdef SWITCH_RESPONSE_CHANGE_REQUIRED_EN
        ok = ok && m_changed;
`endif
        m_hit  = ok;
        m_miss = m_waiting && round_start && !ok;
        if (round_start) begin
            m_target = led_control; m_waiting = 1; m_changed = 0;
        end else if (ok) begin
            m_waiting = 0;
        end else if (m_waiting && nxt != m_stable) begin
            m_changed = 1;
        end
        m_stable = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_stable(input logic [W-1:0] v, input string name);
        int n = 0;
        while (sw_stable !== v && n < 30) begin
            cycle();
            n++;
        end
        check(name, sw_stable, v);
    endtask

    typedef struct {
        logic         tick;
        logic         rs;
        logic [W-1:0] led;
        logic [W-1:0] sw;
        logic [W-1:0] e_stable;
        logic         e_hit, e_miss, e_armed;
    } vec_t;
    vec_t vq [$];

    task automatic add(input logic rs, input logic [W-1:0] led, input logic [W-1:0] sw,
                       input logic [W-1:0] es, input logic eh, input logic em, input logic ea);
        vec_t v;
        v.tick = 1'b1; v.rs = rs; v.led = led; v.sw = sw;
        v.e_stable = es; v.e_hit = eh; v.e_miss = em; v.e_armed = ea;
        vq.push_back(v);
    endtask

    initial begin
        clr = 0; scan_tick = 0; round_start = 0; led_control = '0; switch = '0;
        model_reset();

        // debounce with a 2-tick bounce, then hit, miss, and hit on the new target
        add(0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
        add(0, 8'h00, 8'h01, 8'h01, 0, 0, 0);
        add(0, 8'h00, 8'h01, 8'h01, 0, 0, 0);
        add(1, 8'h07, 8'h01, 8'h01, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h07, 8'h01, 0, 0, 1);
        add(0, 8'h00, 8'h07, 8'h07, 0, 0, 1);
        add(0, 8'h00, 8'h07, 8'h07, 1, 0, 0);
        add(0, 8'h00, 8'h07, 8'h07, 0, 0, 0);
        add(0, 8'h00, 8'h07, 8'h07, 0, 0, 0);
        add(1, 8'hA5, 8'h07, 8'h07, 0, 0, 1);
        add(0, 8'h00, 8'h07, 8'h07, 0, 0, 1);
        add(1, 8'h3C, 8'h07, 8'h07, 0, 1, 1);
        add(0, 8'h00, 8'h07, 8'h07, 0, 0, 1);
        for (int i = 0; i < 4; i++) add(0, 8'h00, 8'h3C, 8'h07, 0, 0, 1);
        add(0, 8'h00, 8'h3C, 8'h3C, 0, 0, 1);
        add(0, 8'h00, 8'h3C, 8'h3C, 1, 0, 0);

        repeat (3) cycle();
        check("reset_stable", sw_stable, 0);
        check("reset_hit", hit, 0);
        check("reset_miss", miss, 0);
        check("reset_armed", armed, 0);
        clr = 1;

        foreach (vq[k]) begin
            scan_tick = vq[k].tick; round_start = vq[k].rs;
            led_control = vq[k].led; switch = vq[k].sw;
            cycle();
            if ({sw_stable, hit, miss, armed} !== {vq[k].e_stable, vq[k].e_hit, vq[k].e_miss, vq[k].e_armed})
                $display("FAIL vec_row_%0d: got stable=%0h hit=%0b miss=%0b armed=%0b expected stable=%0h hit=%0b miss=%0b armed=%0b",
                         k, sw_stable, hit, miss, armed, vq[k].e_stable, vq[k].e_hit, vq[k].e_miss, vq[k].e_armed);
            checks++;
            if ({sw_stable, hit, miss, armed} !== {vq[k].e_stable, vq[k].e_hit, vq[k].e_miss, vq[k].e_armed})
                errors++;
        end

        // round_start in the cycle sw_stable first equals the old target
        round_start = 1; led_control = 8'h3D; switch = 8'h3D;
        cycle();
        round_start = 0;
        wait_stable(8'h3D, "simul_reach");
        round_start = 1; led_control = 8'h55;
        cycle();
        round_start = 0;
        check("simul_hit", hit, 1);
        check("simul_miss", miss, 0);
        check("simul_armed", armed, 1);
        cycle();
        check("simul_rearmed", armed, 1);
        check("simul_hit_once", hit, 0);

        // arm with a pattern the switches already show
        switch = 8'h07;
        wait_stable(8'h07, "chg_pre");
        round_start = 1; led_control = 8'h07;
        cycle();
        round_start = 0;
        check("chg_miss_prev", miss, 1);
        check("chg_armed", armed, 1);
        cycle();
`ifdef SWITCH_RESPONSE_CHANGE_REQUIRED_EN
        check("chg_no_early_hit", hit, 0);
        repeat (3) cycle();
        check("chg_still_armed", {hit, armed}, 2'b01);
        switch = 8'h0F;
        wait_stable(8'h0F, "chg_toggle_on");
        check("chg_toggle_nohit", hit, 0);
        switch = 8'h07;
        wait_stable(8'h07, "chg_toggle_off");
        cycle();
        check("chg_hit", hit, 1);
`else
        check("chg_early_hit", hit, 1);
        check("chg_done", armed, 0);
`endif

        // asynchronous reset mid-round with counters part-way
        round_start = 1; led_control = 8'hAA;
        cycle();
        round_start = 0; switch = 8'hFF;
        repeat (4) cycle();
        #2;
        clr = 0;
        model_reset();
        #1;
        check("arst_stable", sw_stable, 0);
        check("arst_armed", armed, 0);
        check("arst_pulses", {hit, miss}, 0);
        switch = 8'h00;
        repeat (2) cycle();
        clr = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("arst_after", {hit, miss, armed}, 0);
        end

        // random traffic against the model
        for (int n = 0; n < 4000; n++) begin
            scan_tick   = ($urandom_range(0, 2) == 0);
            round_start = ($urandom_range(0, 39) == 0);
            led_control = ($urandom_range(0, 3) == 0) ? m_stable : W'($urandom);
            if ($urandom_range(0, 29) == 0)
                switch = $urandom_range(0, 1) ? m_target : W'($urandom);
            if ($urandom_range(0, 49) == 0)
                switch = switch ^ W'(1 << $urandom_range(0, W - 1));
            cycle();
            check("rnd_stable", sw_stable, m_stable);
            check("rnd_hit", hit, m_hit);
            check("rnd_miss", miss, m_miss);
            check("rnd_armed", armed, m_waiting);
            check("rnd_exclusive", hit & miss, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
